core_mgmt_mailbox_slave: RTL

AXI4-Lite slave endpoint inside core_management. It consumes the register read/write transactions that one Taiga core issues on its s_axi master port. It exposes a core ID register, an inter-core token request/hold register, and a pair of 32-bit mailbox FIFOs. The TX FIFO drains to the peer core's endpoint; the RX FIFO is filled from it. One instance is placed per core.

---
 rtl/core_mgmt_mailbox_slave_pkg.sv | 18 +
 rtl/core_mgmt_mailbox_slave_if.sv | 32 +++
 rtl/core_mgmt_mailbox_slave_mbox_fifo.sv | 59 +++++
 rtl/core_mgmt_mailbox_slave.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/core_mgmt_mailbox_slave_pkg.sv
// Shared types for the core_management mailbox slave: register offsets,
// AXI response codes and the per-channel response state.
package core_mgmt_types;

   // Register index, i.e. address bits [5:2]
   localparam logic [3:0] REG_ID     = 4'h0;
   localparam logic [3:0] REG_TOKEN  = 4'h1;
   localparam logic [3:0] REG_TX     = 4'h2;
   localparam logic [3:0] REG_RX     = 4'h3;
   localparam logic [3:0] REG_STATUS = 4'h4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {CH_IDLE, CH_RESP} ch_state_e;

endpackage

// File: rtl/core_mgmt_mailbox_slave_if.sv
// AXI4-Lite register bus between a Taiga core master and its mailbox slave.
interface core_mgmt_mailbox_slave_if;

   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/core_mgmt_mailbox_slave_mbox_fifo.sv
// Circular-buffer FIFO used for the TX and RX mailboxes; push when full and
// pop when empty are ignored. Full/empty/count reflect the start of the cycle.
module mbox_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage has no reset; clearing the pointers and count empties the FIFO.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/core_mgmt_mailbox_slave.sv
// AXI4-Lite mailbox/token slave for one Taiga core. Define STRICT_AXI_RREADY_EN
// to hold bvalid/rvalid until bready/rready; by default they are 1-cycle pulses.
module core_mgmt_mailbox_slave
   import core_mgmt_types::*;
#(
   parameter int CORE_ID    = 0,
   parameter int MBOX_DEPTH = 4,
   parameter int CNT_W      = $clog2(MBOX_DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   core_mgmt_mailbox_slave_if.slave   s_axi,
   output logic                       token_req,
   input  logic                       token_grant,
   output logic                       tx_valid,
   output logic [31:0]                tx_data,
   input  logic                       tx_ready,
   input  logic                       rx_valid,
   input  logic [31:0]                rx_data,
   output logic                       rx_ready
);

   localparam logic CORE_ID_BIT = CORE_ID[0];

   ch_state_e   wr_state_q, wr_state_d, rd_state_q, rd_state_d;
   logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        token_req_q, token_req_d;

   logic             tx_push, tx_pop, tx_full, tx_empty;
   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic [CNT_W-1:0] tx_count, rx_count;
   logic [31:0]      tx_head, rx_head;
   logic [3:0]       wr_idx, rd_idx;
   logic             unused_bits;

   assign wr_idx      = s_axi.awaddr[5:2];
   assign rd_idx      = s_axi.araddr[5:2];
   assign unused_bits = ^{s_axi.awaddr[31:6], s_axi.awaddr[1:0],
                          s_axi.araddr[31:6], s_axi.araddr[1:0], s_axi.bready, s_axi.rready};

   // Readies come straight from the state flops, never from a valid input.
   assign s_axi.awready = (wr_state_q == CH_IDLE);
   assign s_axi.wready  = (wr_state_q == CH_IDLE);
   assign s_axi.bvalid  = (wr_state_q == CH_RESP);
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = (rd_state_q == CH_IDLE);
   assign s_axi.rvalid  = (rd_state_q == CH_RESP);
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;
   assign token_req     = token_req_q;

   assign tx_valid = !tx_empty;
   assign tx_data  = tx_empty ? '0 : tx_head;
   assign tx_pop   = tx_valid && tx_ready;
   assign rx_ready = !rx_full;
   assign rx_push  = rx_valid && rx_ready;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_state_d  = wr_state_q;
      bresp_d     = bresp_q;
      token_req_d = token_req_q;
      tx_push     = 1'b0;
      case (wr_state_q)
         CH_IDLE: begin
            if (s_axi.awvalid && s_axi.wvalid) begin
               wr_state_d = CH_RESP;
               bresp_d    = RESP_OKAY;
               if (|s_axi.wstrb) begin
                  case (wr_idx)
                     REG_TOKEN: token_req_d = s_axi.wdata[0];
                     REG_TX: begin
                        if (tx_full) bresp_d = RESP_SLVERR;
                        else         tx_push = 1'b1;
                     end
                     REG_ID, REG_RX, REG_STATUS: bresp_d = RESP_SLVERR;
                     default: bresp_d = RESP_DECERR;
                  endcase
               end
            end
         end
         CH_RESP: begin
`ifdef STRICT_AXI_RREADY_EN
            if (s_axi.bready) wr_state_d = CH_IDLE;
`else
            wr_state_d = CH_IDLE;
`endif
         end
         default: wr_state_d = CH_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rx_pop     = 1'b0;
      case (rd_state_q)
         CH_IDLE: begin
            if (s_axi.arvalid) begin
               rd_state_d = CH_RESP;
               rdata_d    = '0;
               rresp_d    = RESP_OKAY;
               case (rd_idx)
                  REG_ID:     rdata_d = {31'b0, CORE_ID_BIT};
                  REG_TOKEN:  rdata_d = {30'b0, token_req_q & token_grant, token_req_q};
                  REG_TX:     rresp_d = RESP_SLVERR;
                  REG_RX: begin
                     if (rx_empty) begin
                        rresp_d = RESP_SLVERR;
                     end else begin
                        rdata_d = rx_head;
                        rx_pop  = 1'b1;
                     end
                  end
                  REG_STATUS: rdata_d = 32'({rx_count, tx_count, rx_empty, tx_full});
                  default:    rresp_d = RESP_DECERR;
               endcase
            end
         end
         CH_RESP: begin
`ifdef STRICT_AXI_RREADY_EN
            if (s_axi.rready) rd_state_d = CH_IDLE;
`else
            rd_state_d = CH_IDLE;
`endif
         end
         default: rd_state_d = CH_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q  <= CH_IDLE;
         rd_state_q  <= CH_IDLE;
         bresp_q     <= '0;
         rresp_q     <= '0;
         rdata_q     <= '0;
         token_req_q <= 1'b0;
      end else begin
         wr_state_q  <= wr_state_d;
         rd_state_q  <= rd_state_d;
         bresp_q     <= bresp_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
         token_req_q <= token_req_d;
      end
   end

   mbox_fifo #(.DEPTH(MBOX_DEPTH), .WIDTH(32), .CNT_W(CNT_W)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_push),
      .wdata (s_axi.wdata),
      .pop   (tx_pop),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count),
      .head  (tx_head)
   );

   mbox_fifo #(.DEPTH(MBOX_DEPTH), .WIDTH(32), .CNT_W(CNT_W)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .wdata (rx_data),
      .pop   (rx_pop),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count),
      .head  (rx_head)
   );

endmodule
